// File: rtl/fetch_pkg.sv
// Shared types and constants for the 6502 instruction-fetch stage.
package fetch_pkg;
  localparam int          ADDR_W        = 16;
  localparam logic [15:0] RESET_VEC_DEF = 16'hFFFC;

  typedef enum logic [1:0] {VEC_LO, VEC_HI, VEC_WAIT, RUN} state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Small flushable sync FIFO holding {byte, pc} entries; head reads as zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Flush wins over everything; a push at full is only taken alongside a pop.
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reset-vector load, credit-limited byte streaming into a
// flushable FIFO, and redirect handling for the frontend.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        din_i,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [7:0]        instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [7:0]        vlo_q, vlo_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;
  logic              req, flush, push, pop, credit_ok;
  logic [CW-1:0]     count;
  logic [23:0]       head;

  // Count the outstanding request against the buffer so its response always fits.
  assign credit_ok = (count + CW'(inflight_q)) < CW'(DEPTH);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    vlo_d    = vlo_q;
    addr_i   = RESET_VEC;
    req      = 1'b0;
    flush    = 1'b0;
    kill_d   = 1'b0;
    case (state_q)
      VEC_LO: state_d = VEC_HI;
      VEC_HI: begin
        addr_i  = RESET_VEC + 16'd1;
        vlo_d   = din_i;
        state_d = VEC_WAIT;
      end
      VEC_WAIT: begin
        addr_i  = RESET_VEC + 16'd1;
        pc_d    = {din_i, vlo_q};
        state_d = RUN;
      end
      RUN: begin
        addr_i = pc_q;
        if (redirect_valid) begin
          flush  = 1'b1;
          kill_d = 1'b1;
          pc_d   = redirect_pc;
        end else if (credit_ok) begin
          req  = 1'b1;
          pc_d = pc_q + 16'd1;
        end
      end
      default: state_d = VEC_LO;
    endcase
    inflight_d = req;
    req_pc_d   = req ? pc_q : req_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= VEC_LO;
      pc_q       <= '0;
      req_pc_q   <= '0;
      vlo_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      vlo_q      <= vlo_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  // A response landing in a redirect cycle is stale too, so flush also blocks it.
  assign push = inflight_q && !kill_q && !flush;
  assign pop  = instr_valid && instr_ready;

  fetch_fifo #(.DEPTH(DEPTH), .W(24)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush),
    .wdata_i({din_i, req_pc_q}),
    .rdata_o(head),
    .count_o(count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head[23:16];
  assign instr_pc    = head[15:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: boot-sequence vector table plus
// scoreboarded streaming, backpressure, redirect, wrap and mid-run reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_i;
  logic [7:0]  din_i;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  fetch_unit #(.DEPTH(4), .RESET_VEC(16'hFFFC)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (addr_i),
    .din_i         (din_i),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the address.
  logic [7:0] mem [0:65535];
  always @(posedge clk) din_i <= mem[addr_i];

  typedef struct packed {logic [7:0] b; logic [15:0] pc;} ent_t;
  ent_t sb[$];

  typedef struct {
    logic        chk_addr;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [7:0]  b;
  } vec_t;
  vec_t tbl [11];

  int checks = 0, failures = 0, npop = 0;
  bit mon_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // Every accepted byte must match the next expected {byte, pc}.
  always @(negedge clk) begin
    ent_t e;
    if (mon_en && !rst && instr_valid && instr_ready && !redirect_valid) begin
      npop++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_pc=%h expected=none", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", {16'h0, instr_pc}, {16'h0, e.pc});
        chk("sb_byte", {24'h0, instr}, {24'h0, e.b});
      end
    end
  end

  task automatic exp_from(input logic [15:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = pc + 16'(i);
      sb.push_back({mem[a], a});
    end
  endtask

  task automatic wait_pops(input string nm, input int target, input int budget);
    int k;
    k = 0;
    while (npop < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(nm, {31'h0, npop >= target}, 32'h1);
  endtask

  task automatic redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb.delete();
    exp_from(pc, 64);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Release reset on a falling edge and step the boot sequence with ready low.
  task automatic run_table(input string nm);
    sb.delete();
    exp_from(16'h1234, 64);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      #1;
      if (tbl[k].chk_addr)
        chk($sformatf("%s_addr_k%0d", nm, k), {16'h0, addr_i}, {16'h0, tbl[k].addr});
      chk($sformatf("%s_valid_k%0d", nm, k), {31'h0, instr_valid}, {31'h0, tbl[k].valid});
      chk($sformatf("%s_pc_k%0d", nm, k), {16'h0, instr_pc}, {16'h0, tbl[k].pc});
      chk($sformatf("%s_instr_k%0d", nm, k), {24'h0, instr}, {24'h0, tbl[k].b});
      @(negedge clk);
    end
  endtask

  initial begin
    int n0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    for (int i = 0; i < 8; i++) mem[16'h1234 + i] = 8'(i);

    // Cycles after reset release: vector fetch, first RUN fetch at k=3,
    // first byte visible at k=5, credits exhausted with pc stuck at 1238.
    tbl[0]  = '{1'b1, 16'hFFFC, 1'b0, 16'h0000, 8'h00};
    tbl[1]  = '{1'b1, 16'hFFFD, 1'b0, 16'h0000, 8'h00};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00};
    tbl[3]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, 8'h00};
    tbl[4]  = '{1'b1, 16'h1235, 1'b0, 16'h0000, 8'h00};
    tbl[5]  = '{1'b1, 16'h1236, 1'b1, 16'h1234, 8'h00};
    tbl[6]  = '{1'b1, 16'h1237, 1'b1, 16'h1234, 8'h00};
    tbl[7]  = '{1'b1, 16'h1238, 1'b1, 16'h1234, 8'h00};
    tbl[8]  = '{1'b1, 16'h1238, 1'b1, 16'h1234, 8'h00};
    tbl[9]  = '{1'b1, 16'h1238, 1'b1, 16'h1234, 8'h00};
    tbl[10] = '{1'b1, 16'h1238, 1'b1, 16'h1234, 8'h00};

    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", {16'h0, addr_i}, 32'hFFFC);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", {24'h0, instr}, 32'h0);
    chk("rst_pc", {16'h0, instr_pc}, 32'h0);

    run_table("boot");

    // Release backpressure: full buffer drains and then streams one byte per cycle.
    @(posedge clk); #1;
    instr_ready = 1'b1;
    n0 = npop;
    repeat (20) @(posedge clk);
    chk("throughput", 32'(npop - n0), 32'd20);
    #1;
    instr_ready = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid", {31'h0, instr_valid}, 32'h1);
    chk("bp_head", {16'h0, instr_pc}, {16'h0, sb[0].pc});
    chk("bp_addr_stall", {16'h0, addr_i}, {16'h0, sb[0].pc + 16'd4});
    @(posedge clk); #1;
    chk("bp_addr_hold", {16'h0, addr_i}, {16'h0, sb[0].pc + 16'd4});

    // One pop leaves 3 buffered, frees a credit; redirect while that fetch is in flight.
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    @(posedge clk); #1;
    redirect(16'h0200);
    chk("redir_addr", {16'h0, addr_i}, 32'h0200);
    chk("redir_flush", {31'h0, instr_valid}, 32'h0);
    instr_ready = 1'b1;
    wait_pops("redir_stream", npop + 6, 40);

    // Back-to-back redirects: the second one wins.
    redirect(16'h0300);
    redirect(16'h0400);
    chk("b2b_addr", {16'h0, addr_i}, 32'h0400);
    wait_pops("b2b_stream", npop + 6, 40);

    redirect(16'hFFFE);
    wait_pops("wrap_stream", npop + 5, 40);

    // Fill the buffer, then reset mid-run.
    instr_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("full_valid", {31'h0, instr_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_addr", {16'h0, addr_i}, 32'hFFFC);
    chk("mid_rst_pc", {16'h0, instr_pc}, 32'h0);
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    run_table("reboot");
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_pops("reboot_stream", npop + 8, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
